// File: rtl/alu_acc.sv
// Single-stage ALU with an accumulator and a registered result/flag output
// behind a valid/ready handshake on both sides.
module alu_acc #(
  parameter int WIDTH    = 16,
  parameter     AND_MASK = 16'h0FFF,
  parameter     OR_MASK  = 16'h00FF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [2:0]       in_opcode,
  input  logic             in_src_acc,
  input  logic             in_acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_neg,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [WIDTH-1:0] AND_M = WIDTH'(AND_MASK);
  localparam logic [WIDTH-1:0] OR_M  = WIDTH'(OR_MASK);

  // Returns {carry, result}; carry is the bit shifted/borrowed/carried out.
  function automatic logic [WIDTH:0] alu_eval(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      3'b000:  r = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
      3'b001:  r = {(x == '0), x - {{(WIDTH-1){1'b0}}, 1'b1}};
      3'b010:  r = {1'b0, ~x};
      3'b011:  r = {1'b0, x & AND_M};
      3'b100:  r = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
      3'b101:  r = {x[0], 1'b0, x[WIDTH-1:1]};
      3'b110:  r = {1'b0, x | OR_M};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                    vld_p1;
  logic signed [WIDTH-1:0] res_p1;
  logic                    zero_p1, carry_p1, neg_p1;
  logic        [WIDTH-1:0] acc_q;
  logic        [CNT_W-1:0] cnt_q;

  logic        [WIDTH-1:0] x_p0;
  logic signed [WIDTH-1:0] res_p0;
  logic                    carry_p0;
  logic                    accept_p0, out_hs;

  assign in_ready  = !vld_p1 | out_ready;
  assign accept_p0 = in_valid & in_ready;
  assign out_hs    = vld_p1 & out_ready;

  // Stage p0: operand select and combinational ALU in the accept cycle
  always_comb begin
    x_p0               = in_src_acc ? acc_q : in_a;
    {carry_p0, res_p0} = alu_eval(in_opcode, x_p0);
  end

  // Stage p1: output register, accumulator and consumed-result counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      zero_p1  <= 1'b1;
      carry_p1 <= 1'b0;
      neg_p1   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept_p0) begin
        vld_p1   <= 1'b1;
        res_p1   <= res_p0;
        zero_p1  <= (res_p0 == '0);
        carry_p1 <= carry_p0;
        neg_p1   <= (res_p0 < 0);
        if (in_acc_wr) acc_q <= res_p0;
      end else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
      if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = vld_p1;
  assign out_result = res_p1;
  assign out_zero   = zero_p1;
  assign out_carry  = carry_p1;
  assign out_neg    = neg_p1;
  assign acc        = acc_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_acc.sv
// Bench for alu_acc: a 16-bit instance and an 8-bit/4-bit-counter instance
// driven side by side and compared each cycle with an arithmetic model.
module tb_alu_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv[2], isrc[2], iwr[2], ordy[2];
  logic [15:0] ia[2];
  logic [2:0]  iop[2];

  logic        ir_0, ov_0, oz_0, oc_0, on_0;
  logic [15:0] res_0, acc_0, cnt_0;
  logic        ir_1, ov_1, oz_1, oc_1, on_1;
  logic [7:0]  res_1, acc_1;
  logic [3:0]  cnt_1;

  logic        ir[2], ov[2], oz[2], oc[2], on[2];
  logic [15:0] ores[2], oacc[2], ocnt[2];

  always_comb begin
    ir[0] = ir_0; ov[0] = ov_0; oz[0] = oz_0; oc[0] = oc_0; on[0] = on_0;
    ores[0] = res_0; oacc[0] = acc_0; ocnt[0] = cnt_0;
    ir[1] = ir_1; ov[1] = ov_1; oz[1] = oz_1; oc[1] = oc_1; on[1] = on_1;
    ores[1] = {8'h00, res_1}; oacc[1] = {8'h00, acc_1}; ocnt[1] = {12'h000, cnt_1};
  end

  alu_acc u16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir_0), .in_a(ia[0]),
    .in_opcode(iop[0]), .in_src_acc(isrc[0]), .in_acc_wr(iwr[0]),
    .out_valid(ov_0), .out_ready(ordy[0]), .out_result(res_0),
    .out_zero(oz_0), .out_carry(oc_0), .out_neg(on_0), .acc(acc_0), .op_count(cnt_0)
  );

  alu_acc #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir_1), .in_a(ia[1][7:0]),
    .in_opcode(iop[1]), .in_src_acc(isrc[1]), .in_acc_wr(iwr[1]),
    .out_valid(ov_1), .out_ready(ordy[1]), .out_result(res_1),
    .out_zero(oz_1), .out_carry(oc_1), .out_neg(on_1), .acc(acc_1), .op_count(cnt_1)
  );

  // Reference state: what each instance should be holding
  int     wd[2] = '{16, 8};
  int     cw[2] = '{16, 4};
  bit     ev[2], ec[2], ez[2], en[2];
  longint er[2], eacc[2], ecnt[2];
  int     n_assert = 0;
  int     n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_alu(input int op, input longint x, input int w,
                           output longint r, output bit c);
    longint m;
    m = longint'(1) << w;
    c = 1'b0;
    r = 0;
    case (op)
      0: begin r = (x + 1) % m; c = (x + 1) >= m; end
      1: begin r = (x + m - 1) % m; c = (x == 0); end
      2: r = m - 1 - x;
      3: r = x & (longint'(16'h0FFF) % m);
      4: begin r = (x * 2) % m; c = (x * 2) >= m; end
      5: begin r = x / 2; c = (x % 2) == 1; end
      6: r = x | (longint'(16'h00FF) % m);
      default: r = 0;
    endcase
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 0; er[k] = 0; ec[k] = 0; ez[k] = 1; en[k] = 0; eacc[k] = 0; ecnt[k] = 0;
    end
  endtask

  task automatic drive(input int k, input bit v, input logic [15:0] a, input int op,
                       input bit src, input bit wr, input bit rdy);
    iv[k] = v; ia[k] = a; iop[k] = 3'(op); isrc[k] = src; iwr[k] = wr; ordy[k] = rdy;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.out_valid", k), 64'(ov[k]), 64'(ev[k]));
      chk($sformatf("u%0d.out_result", k), 64'(ores[k]), 64'(er[k]));
      chk($sformatf("u%0d.out_zero", k), 64'(oz[k]), 64'(ez[k]));
      chk($sformatf("u%0d.out_carry", k), 64'(oc[k]), 64'(ec[k]));
      chk($sformatf("u%0d.out_neg", k), 64'(on[k]), 64'(en[k]));
      chk($sformatf("u%0d.acc", k), 64'(oacc[k]), 64'(eacc[k]));
      chk($sformatf("u%0d.op_count", k), 64'(ocnt[k]), 64'(ecnt[k]));
    end
  endtask

  task automatic tick();
    longint m, x, r;
    bit     c, acc_ok, hs;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("u%0d.in_ready", k), 64'(ir[k]), 64'(!ev[k] || ordy[k]));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m      = longint'(1) << wd[k];
      acc_ok = iv[k] && (!ev[k] || ordy[k]);
      hs     = ev[k] && ordy[k];
      if (hs) ecnt[k] = (ecnt[k] + 1) % (longint'(1) << cw[k]);
      if (acc_ok) begin
        x = isrc[k] ? eacc[k] : longint'(ia[k]) % m;
        model_alu(int'(iop[k]), x, wd[k], r, c);
        er[k] = r; ec[k] = c; ez[k] = (r == 0); en[k] = (r >= m / 2); ev[k] = 1;
        if (iwr[k]) eacc[k] = r;
      end else if (hs) begin
        ev[k] = 0;
      end
    end
    #1;
    check_all();
  endtask

  longint saved_cnt;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) drive(k, 1, 16'hFFFF, 0, 0, 1, 0);
    reset_model();
    #2;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    chk("rst.in_ready0", 64'(ir[0]), 64'd1);
    chk("rst.in_ready1", 64'(ir[1]), 64'd1);
    rst = 1'b0;

    // Increment carry-out on 16 bits; decrement borrow on 8 bits
    drive(0, 1, 16'hFFFF, 0, 0, 0, 1);
    drive(1, 1, 16'h0000, 1, 0, 0, 1);
    tick();
    chk("inc.res", 64'(ores[0]), 64'h0);
    chk("inc.zero", 64'(oz[0]), 64'd1);
    chk("inc.carry", 64'(oc[0]), 64'd1);
    chk("inc.neg", 64'(on[0]), 64'd0);
    chk("dec8.res", 64'(ores[1]), 64'hFF);
    chk("dec8.carry", 64'(oc[1]), 64'd1);
    chk("dec8.neg", 64'(on[1]), 64'd1);
    drive(0, 0, 16'h0, 0, 0, 0, 1);
    drive(1, 1, 16'h00FF, 3, 0, 0, 1);
    tick();
    chk("inc.count", 64'(ocnt[0]), 64'd1);
    chk("and8.res", 64'(ores[1]), 64'hFF);
    drive(1, 1, 16'h0000, 6, 0, 0, 1);
    tick();
    chk("or8.res", 64'(ores[1]), 64'hFF);
    drive(1, 0, 16'h0, 0, 0, 0, 1);
    tick();

    // Accumulator chaining on consecutive accepts
    drive(0, 1, 16'h8001, 4, 0, 1, 1);
    tick();
    chk("chain.shl.res", 64'(ores[0]), 64'h0002);
    chk("chain.shl.carry", 64'(oc[0]), 64'd1);
    drive(0, 1, 16'h0000, 5, 1, 1, 1);
    tick();
    chk("chain.shr.res", 64'(ores[0]), 64'h0001);
    chk("chain.shr.carry", 64'(oc[0]), 64'd0);
    chk("chain.acc", 64'(oacc[0]), 64'h0001);
    drive(0, 0, 16'h0, 0, 0, 0, 1);
    tick();

    // Backpressure: pending result held while a new request waits
    drive(0, 1, 16'h00A5, 2, 0, 0, 0);
    tick();
    drive(0, 1, 16'h0042, 0, 0, 0, 0);
    repeat (5) tick();
    chk("bp.in_ready", 64'(ir[0]), 64'd0);
    chk("bp.res", 64'(ores[0]), 64'hFF5A);
    saved_cnt = longint'(ocnt[0]);
    drive(0, 1, 16'h0042, 0, 0, 0, 1);
    tick();
    chk("bp.count", 64'(ocnt[0]), 64'(saved_cnt + 1));
    chk("bp.newres", 64'(ores[0]), 64'h0043);
    chk("bp.valid", 64'(ov[0]), 64'd1);
    drive(0, 0, 16'h0, 0, 0, 0, 1);
    tick();

    // Asynchronous reset between edges with a pending result
    drive(0, 1, 16'h1233, 0, 0, 1, 0);
    tick();
    chk("ar.acc_before", 64'(oacc[0]), 64'h1234);
    chk("ar.valid_before", 64'(ov[0]), 64'd1);
    drive(0, 0, 16'h0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #2;
    reset_model();
    check_all();
    chk("ar.in_ready0", 64'(ir[0]), 64'd1);
    rst = 1'b0;
    #1;
    drive(0, 0, 16'h0, 0, 0, 0, 1);
    tick();
    chk("ar.count_after", 64'(ocnt[0]), 64'd0);

    // 17 back-to-back handshakes on the 4-bit counter
    drive(1, 1, 16'h0001, 0, 0, 0, 1);
    repeat (18) tick();
    chk("wrap.count", 64'(ocnt[1]), 64'd1);

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++)
        drive(k, $urandom_range(0, 3) != 0, 16'($urandom), int'($urandom_range(0, 7)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0);
      tick();
    end
    for (int k = 0; k < 2; k++) drive(k, 0, 16'h0, 0, 0, 0, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc.md
ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 Parameter WIDTH, default 16: operand, result and accumulator width, minimum 2.
REQ-002 Parameter AND_MASK, default 16'h0FFF zero-extended/truncated to WIDTH: mask for opcode 011.
REQ-003 Parameter OR_MASK, default 16'h00FF zero-extended/truncated to WIDTH: mask for opcode 110.
REQ-004 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 in_a  input  WIDTH  external operand.
REQ-010 in_opcode  input  3  operation select.
REQ-011 in_src_acc  input  1  1: operand is the accumulator, 0: operand is in_a.
REQ-012 in_acc_wr  input  1  1: write the result into the accumulator on acceptance.
REQ-013 out_valid  output  1  result held in the output register.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 out_result  output  WIDTH  registered result.
REQ-016 out_zero, out_carry, out_neg  output  1 each  registered status flags for out_result.
REQ-017 acc  output  WIDTH  current accumulator value.
REQ-018 op_count  output  CNT_W  number of results consumed, modulo 2^CNT_W.

Function
REQ-019 Accept = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-020 in_ready SHALL equal (!out_valid | out_ready), combinationally; no other input path to in_ready.
REQ-021 Operand X = acc when in_src_acc = 1, otherwise in_a, sampled in the accept cycle.
REQ-022 Opcodes: 000 X+1; 001 X-1; 010 ~X; 011 X & AND_MASK; 100 X<<1; 101 X>>1 (logical); 110 X | OR_MASK; 111 all zeros; all results truncated to WIDTH.
REQ-023 out_carry: 000 carry out of bit WIDTH-1 (X all ones); 001 borrow (X = 0); 100 old X[WIDTH-1]; 101 old X[0]; all other opcodes 0.
REQ-024 out_zero = (result == 0); out_neg = result[WIDTH-1].
REQ-025 Latency exactly 1: on an accept at edge N, out_result/flags/out_valid = 1 are visible after edge N.
REQ-026 On accept, the output register and flags SHALL load unconditionally, including when an output handshake occurs in the same cycle (throughput 1 result/cycle).
REQ-027 Without an accept, an output handshake SHALL clear out_valid; out_result and flags hold their last values.
REQ-028 While out_valid = 1 and out_ready = 0, out_result, flags and out_valid SHALL remain stable.
REQ-029 On accept with in_acc_wr = 1, acc SHALL take the result at the same edge; a following accept with in_src_acc = 1 uses the new value (back-to-back chaining, no bubble).
REQ-030 With in_acc_wr = 0 or no accept, acc SHALL hold.
REQ-031 op_count SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-032 Inputs other than in_valid are don't-care when in_valid = 0; no state changes.

Reset
REQ-033 Asserting rst SHALL immediately, independent of clk, set out_valid = 0, out_result = 0, out_zero = 1, out_carry = 0, out_neg = 0, acc = 0, op_count = 0.
REQ-034 While rst = 1, in_ready SHALL be 1 (derived from out_valid = 0) but no accept takes effect; a result pending when rst rises is discarded and not counted.
REQ-035 First accept is possible at the first rising edge after rst deasserts.

Verification
REQ-036 WIDTH=16: in_a=16'hFFFF, op 000, out_ready=1 -> next cycle out_result=0, out_zero=1, out_carry=1, out_neg=0, op_count 0->1 after handshake.
REQ-037 WIDTH=16: acc chain: in_a=16'h8001 op 100 acc_wr=1, then src_acc=1 op 101 acc_wr=1 on consecutive cycles -> results 16'h0002 (carry=1) then 16'h0001 (carry=0), acc=16'h0001.
REQ-038 Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, in_valid held 5 cycles, out_result stable; raise out_ready -> one handshake, new request accepted same cycle, op_count +1.
REQ-039 WIDTH=8: in_a=8'h00 op 001 -> 8'hFF, carry=1, neg=1; op 011 on 8'hFF -> 8'hFF (AND_MASK truncated to 8'hFF); op 110 on 8'h00 -> 8'hFF.
REQ-040 Async reset mid-stream: rst pulsed between clock edges with out_valid=1, acc=16'h1234 -> out_valid, acc, op_count read 0 before next edge; no pending result emitted.
REQ-041 CNT_W=4: 17 consecutive handshakes -> op_count wraps to 1.
